// File: rtl/guineveer_mem2axi.sv
// guineveer_mem2axi: single-outstanding bridge from a req/gnt/rvalid memory port to one AXI4 manager port.
// Optional feature macro GUINEVEER_MEM2AXI_ERR_EN: report SLVERR/DECERR on mem_err_o and zero errored read data.

typedef struct packed {
    logic [0:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic [0:0]  user;
} guineveer_mem2axi_aw_t;

typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic [0:0]  user;
} guineveer_mem2axi_w_t;

typedef struct packed {
    logic [0:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
} guineveer_mem2axi_ar_t;

typedef struct packed {
    logic [0:0] id;
    logic [1:0] resp;
    logic [0:0] user;
} guineveer_mem2axi_b_t;

typedef struct packed {
    logic [0:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
} guineveer_mem2axi_r_t;

typedef struct packed {
    guineveer_mem2axi_aw_t aw;
    logic                  aw_valid;
    guineveer_mem2axi_w_t  w;
    logic                  w_valid;
    logic                  b_ready;
    guineveer_mem2axi_ar_t ar;
    logic                  ar_valid;
    logic                  r_ready;
} guineveer_mem2axi_req_t;

typedef struct packed {
    logic                 aw_ready;
    logic                 ar_ready;
    logic                 w_ready;
    logic                 b_valid;
    guineveer_mem2axi_b_t b;
    logic                 r_valid;
    guineveer_mem2axi_r_t r;
} guineveer_mem2axi_resp_t;

module guineveer_mem2axi #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 1,
    parameter type AXI_REQ_T  = guineveer_mem2axi_req_t,
    parameter type AXI_RESP_T = guineveer_mem2axi_resp_t
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    mem_req_i,
    output logic                    mem_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic                    mem_we_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] mem_strb_i,
    output logic                    mem_rvalid_o,
    output logic [DATA_WIDTH-1:0]   mem_rdata_o,
    output logic                    mem_err_o,
    output AXI_REQ_T                axi_req_o,
    input  AXI_RESP_T               axi_resp_i
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned AXI_SIZE = $clog2(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_W - 1);
    localparam logic [ID_WIDTH-1:0] AXI_ID = '0;

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B} state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_strb;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;
    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic                    w_r_hs;
    logic                    w_b_hs;
    logic                    w_rd_err;
    logic                    w_wr_err;
    logic                    w_unused;

    assign w_aw_hs = (r_state == S_AWW) && !r_aw_done && axi_resp_i.aw_ready;
    assign w_w_hs  = (r_state == S_AWW) && !r_w_done && axi_resp_i.w_ready;
    assign w_r_hs  = (r_state == S_R) && axi_resp_i.r_valid;
    assign w_b_hs  = (r_state == S_B) && axi_resp_i.b_valid;

`ifdef GUINEVEER_MEM2AXI_ERR_EN
    // resp[1] set means SLVERR (2'b10) or DECERR (2'b11)
    assign w_rd_err = axi_resp_i.r.resp[1];
    assign w_wr_err = axi_resp_i.b.resp[1];
`else
    assign w_rd_err = 1'b0;
    assign w_wr_err = 1'b0;
`endif

    assign w_unused = ^{axi_resp_i, mem_addr_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_gnt_o   = 1'b0;
        axi_req_o   = '0;
        axi_req_o.aw.id    = AXI_ID;
        axi_req_o.aw.addr  = r_addr;
        axi_req_o.aw.size  = 3'(AXI_SIZE);
        axi_req_o.aw.burst = 2'b01;
        axi_req_o.w.data   = r_wdata;
        axi_req_o.w.strb   = r_strb;
        axi_req_o.w.last   = 1'b1;
        axi_req_o.ar.id    = AXI_ID;
        axi_req_o.ar.addr  = r_addr;
        axi_req_o.ar.size  = 3'(AXI_SIZE);
        axi_req_o.ar.burst = 2'b01;
        case (r_state)
            S_IDLE: begin
                mem_gnt_o = mem_req_i;
                if (mem_req_i) begin
                    w_state_nxt = mem_we_i ? S_AWW : S_AR;
                end
            end
            S_AR: begin
                axi_req_o.ar_valid = 1'b1;
                if (axi_resp_i.ar_ready) begin
                    w_state_nxt = S_R;
                end
            end
            S_R: begin
                axi_req_o.r_ready = 1'b1;
                if (axi_resp_i.r_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_AWW: begin
                // AW and W complete independently; leave only once both are done
                axi_req_o.aw_valid = !r_aw_done;
                axi_req_o.w_valid  = !r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_state_nxt = S_B;
                end
            end
            S_B: begin
                axi_req_o.b_ready = 1'b1;
                if (axi_resp_i.b_valid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_rvalid <= w_r_hs || w_b_hs;
            if (mem_gnt_o) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
            if (w_r_hs) begin
                r_rdata <= w_rd_err ? '0 : axi_resp_i.r.data;
                r_err   <= w_rd_err;
            end
            if (w_b_hs) begin
                r_err <= w_wr_err;
            end
        end
    end

    // request payload is only consumed while a transaction is in flight
    always_ff @(posedge clk_i) begin
        if (mem_gnt_o) begin
            r_addr  <= mem_addr_i & ALIGN_MASK;
            r_wdata <= mem_wdata_i;
            r_strb  <= mem_strb_i;
        end
    end

    assign mem_rvalid_o = r_rvalid;
    assign mem_rdata_o  = r_rdata;
    assign mem_err_o    = r_err;

endmodule

// File: tb/tb_guineveer_mem2axi.sv
// Testbench for guineveer_mem2axi: AXI subordinate model with programmable stalls plus a
// transaction-level reference memory predicting read data, error flags and response latency.

module tb_guineveer_mem2axi;

`ifdef GUINEVEER_MEM2AXI_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_strb;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_err;
    guineveer_mem2axi_req_t  axi_req;
    guineveer_mem2axi_resp_t axi_resp = '0;

    int n_tests = 0;
    int n_fail  = 0;

    guineveer_mem2axi dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .mem_req_i    (mem_req),
        .mem_gnt_o    (mem_gnt),
        .mem_addr_i   (mem_addr),
        .mem_we_i     (mem_we),
        .mem_wdata_i  (mem_wdata),
        .mem_strb_i   (mem_strb),
        .mem_rvalid_o (mem_rvalid),
        .mem_rdata_o  (mem_rdata),
        .mem_err_o    (mem_err),
        .axi_req_o    (axi_req),
        .axi_resp_i   (axi_resp)
    );

    always #5 clk = ~clk;

    // subordinate configuration and observation
    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [1:0] r_resp_cfg = 2'b00, b_resp_cfg = 2'b00;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, aw_done, w_done, b_pend, ar_waiting;
    int n_ar = 0, n_aw = 0, n_w = 0, proto_err = 0, ar_valid_cycles = 0;
    int outstanding = 0, max_out = 0;
    logic [31:0] seen_ar_addr, seen_aw_addr;
    logic [2:0]  seen_ar_size, seen_aw_size;
    logic [7:0]  seen_ar_len, seen_aw_len;
    logic [1:0]  seen_ar_burst;
    logic [63:0] seen_wdata;
    logic [7:0]  seen_wstrb;
    logic        seen_wlast;

    logic [63:0] smem [logic [31:0]];
    logic [63:0] ref_mem [logic [31:0]];
    logic [63:0] last_rdata = 64'h0;

    function automatic logic [63:0] init_word(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] res;
        res = old;
        for (int i = 0; i < 8; i++) if (s[i]) res[i*8 +: 8] = d[i*8 +: 8];
        return res;
    endfunction

    function automatic logic [63:0] smem_rd(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : init_word(a);
    endfunction

    function automatic logic [63:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Subordinate: decides readies/valids on the falling edge, so any valid&ready pair
    // set up here completes on the following rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            axi_resp = '0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
            r_pend = 0; aw_done = 0; w_done = 0; b_pend = 0; ar_waiting = 0;
            outstanding = 0;
        end else begin
            if (ar_hs) begin
                axi_resp.ar_ready = 1'b0; ar_hs = 0; r_pend = 1; r_cnt = 0;
                if (axi_req.ar_valid) proto_err++;
            end
            if (r_hs) begin
                axi_resp.r_valid = 1'b0; r_hs = 0; outstanding--;
            end
            if (aw_hs) begin
                axi_resp.aw_ready = 1'b0; aw_hs = 0; aw_done = 1;
                if (axi_req.aw_valid) proto_err++;
            end
            if (w_hs) begin
                axi_resp.w_ready = 1'b0; w_hs = 0; w_done = 1;
                if (axi_req.w_valid) proto_err++;
            end
            if (aw_done && w_done) begin
                aw_done = 0; w_done = 0; b_pend = 1; b_cnt = 0;
                smem[seen_aw_addr] = merge(smem_rd(seen_aw_addr), seen_wdata, seen_wstrb);
            end
            if (b_hs) begin
                axi_resp.b_valid = 1'b0; b_hs = 0; outstanding--;
            end
            if (axi_req.ar_valid && !axi_resp.ar_ready) begin
                ar_valid_cycles++;
                if (ar_waiting && axi_req.ar.addr != seen_ar_addr) proto_err++;
                ar_waiting = 1;
                seen_ar_addr = axi_req.ar.addr; seen_ar_size = axi_req.ar.size;
                seen_ar_len = axi_req.ar.len; seen_ar_burst = axi_req.ar.burst;
                if (ar_cnt >= ar_dly) begin
                    axi_resp.ar_ready = 1'b1; ar_hs = 1; ar_cnt = 0; ar_waiting = 0;
                    n_ar++; outstanding++;
                    if (outstanding > max_out) max_out = outstanding;
                end else ar_cnt++;
            end
            if (r_pend && !axi_resp.r_valid) begin
                if (r_cnt >= r_dly) begin
                    axi_resp.r_valid = 1'b1; axi_resp.r.data = smem_rd(seen_ar_addr);
                    axi_resp.r.resp = r_resp_cfg; axi_resp.r.last = 1'b1;
                    r_pend = 0; r_hs = 1;
                    if (!axi_req.r_ready) proto_err++;
                end else r_cnt++;
            end
            if (axi_req.aw_valid && !axi_resp.aw_ready) begin
                seen_aw_addr = axi_req.aw.addr; seen_aw_size = axi_req.aw.size; seen_aw_len = axi_req.aw.len;
                if (aw_cnt >= aw_dly) begin
                    axi_resp.aw_ready = 1'b1; aw_hs = 1; aw_cnt = 0; n_aw++; outstanding++;
                    if (outstanding > max_out) max_out = outstanding;
                end else aw_cnt++;
            end
            if (axi_req.w_valid && !axi_resp.w_ready) begin
                seen_wdata = axi_req.w.data; seen_wstrb = axi_req.w.strb; seen_wlast = axi_req.w.last;
                if (w_cnt >= w_dly) begin
                    axi_resp.w_ready = 1'b1; w_hs = 1; w_cnt = 0; n_w++;
                end else w_cnt++;
            end
            if (b_pend && !axi_resp.b_valid) begin
                if (b_cnt >= b_dly) begin
                    axi_resp.b_valid = 1'b1; axi_resp.b.resp = b_resp_cfg;
                    b_pend = 0; b_hs = 1;
                    if (!axi_req.b_ready) proto_err++;
                end else b_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_delays(input int ar, input int r, input int aw, input int w, input int b);
        ar_dly = ar; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
    endtask

    // One memory transaction; entered and left just after a falling edge.
    task automatic run_op(input string tag, input bit we, input logic [31:0] a,
                          input logic [63:0] d, input logic [7:0] s, input bit hold);
        logic [31:0] al;
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          exp_lat, lat, cnt, busy_gnt;
        bit          got;
        al = a & ~32'h7;
        mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = d; mem_strb = s;
        #1;
        cnt = 0;
        while (mem_gnt !== 1'b1 && cnt < 40) begin
            @(negedge clk); #1; cnt++;
        end
        check({tag, ".gnt"}, 64'(mem_gnt), 64'd1);
        if (we) begin
            ref_mem[al] = merge(ref_rd(al), d, s);
            exp_err   = ERR_EN && b_resp_cfg[1];
            exp_rdata = last_rdata;
            exp_lat   = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
        end else begin
            exp_err   = ERR_EN && r_resp_cfg[1];
            exp_rdata = exp_err ? 64'h0 : ref_rd(al);
            last_rdata = exp_rdata;
            exp_lat   = 3 + ar_dly + r_dly;
        end
        lat = 0; got = 0; busy_gnt = 0;
        while (!got && lat < 200) begin
            @(negedge clk); #1; lat++;
            if (mem_rvalid === 1'b1) got = 1;
            else if (mem_gnt !== 1'b0) busy_gnt++;
            if (!hold) mem_req = 1'b0;
        end
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".rdata"}, mem_rdata, exp_rdata);
        check({tag, ".err"}, 64'(mem_err), 64'(exp_err));
        check({tag, ".gnt_busy"}, 64'(busy_gnt), 64'd0);
        if (hold) check({tag, ".gnt_b2b"}, 64'(mem_gnt), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0_aw, n0_w, cnt, bad;
        rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_strb = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset.gnt", 64'(mem_gnt), 64'd0);
        check("reset.rvalid", 64'(mem_rvalid), 64'd0);
        check("reset.rdata", mem_rdata, 64'd0);
        check("reset.err", 64'(mem_err), 64'd0);
        check("reset.axi_handshake", 64'({axi_req.ar_valid, axi_req.r_ready, axi_req.aw_valid,
              axi_req.w_valid, axi_req.b_ready}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // zero-wait read
        smem[32'h100] = 64'hDEADBEEF_01234567;
        ref_mem[32'h100] = 64'hDEADBEEF_01234567;
        set_delays(0, 0, 0, 0, 0);
        run_op("rd100", 1'b0, 32'h100, 64'h0, 8'h00, 1'b0);
        check("rd100.ar_addr", 64'(seen_ar_addr), 64'h100);
        check("rd100.ar_size", 64'(seen_ar_size), 64'd3);
        check("rd100.ar_len", 64'(seen_ar_len), 64'd0);
        check("rd100.ar_burst", 64'(seen_ar_burst), 64'd1);

        // write with W accepted two cycles before AW
        n0_aw = n_aw; n0_w = n_w;
        set_delays(0, 0, 2, 0, 1);
        run_op("wr108", 1'b1, 32'h108, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1'b0);
        check("wr108.n_aw", 64'(n_aw - n0_aw), 64'd1);
        check("wr108.n_w", 64'(n_w - n0_w), 64'd1);
        check("wr108.aw_addr", 64'(seen_aw_addr), 64'h108);
        check("wr108.aw_size_len", 64'({seen_aw_size, seen_aw_len}), 64'({3'd3, 8'd0}));
        check("wr108.wstrb", 64'(seen_wstrb), 64'h0F);
        check("wr108.wlast", 64'(seen_wlast), 64'd1);
        check("wr108.proto", 64'(proto_err), 64'd0);

        // unaligned read returns the merged word written above
        set_delays(0, 0, 0, 0, 0);
        run_op("rd10d", 1'b0, 32'h10D, 64'h0, 8'h00, 1'b0);
        check("rd10d.ar_addr", 64'(seen_ar_addr), 64'h108);

        // back-to-back with request held high
        run_op("b2b0", 1'b0, 32'h100, 64'h0, 8'h00, 1'b1);
        run_op("b2b1", 1'b1, 32'h110, 64'h0123_4567_89AB_CDEF, 8'hF0, 1'b1);
        run_op("b2b2", 1'b0, 32'h110, 64'h0, 8'h00, 1'b1);
        mem_req = 1'b0;
        check("b2b.max_outstanding", 64'(max_out), 64'd1);

        // stalled AR and delayed R
        ar_valid_cycles = 0;
        set_delays(5, 7, 0, 0, 0);
        run_op("stall", 1'b0, 32'h118, 64'h0, 8'h00, 1'b1);
        mem_req = 1'b0;
        check("stall.ar_valid_cycles", 64'(ar_valid_cycles), 64'd6);
        check("stall.proto", 64'(proto_err), 64'd0);

        // error responses
        smem[32'h200] = 64'h55; ref_mem[32'h200] = 64'h55;
        set_delays(0, 0, 0, 0, 0);
        r_resp_cfg = 2'b10;
        run_op("slverr_rd", 1'b0, 32'h200, 64'h0, 8'h00, 1'b0);
        r_resp_cfg = 2'b00;
        b_resp_cfg = 2'b11;
        run_op("decerr_wr", 1'b1, 32'h208, 64'h77, 8'hFF, 1'b0);
        b_resp_cfg = 2'b00;
        run_op("okay_rd", 1'b0, 32'h200, 64'h0, 8'h00, 1'b0);

        // randomized traffic
        for (int i = 0; i < 16; i++) begin
            bit rw, hold;
            logic [31:0] a;
            rw = 1'($urandom_range(0, 1));
            hold = 1'($urandom_range(0, 1));
            a = 32'h300 + 32'($urandom_range(0, 7) * 8) + 32'($urandom_range(0, 7));
            set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            r_resp_cfg = 2'($urandom_range(0, 3));
            b_resp_cfg = 2'($urandom_range(0, 3));
            run_op($sformatf("rand%0d", i), rw, a, {$urandom, $urandom}, 8'($urandom), hold);
        end
        mem_req = 1'b0;
        r_resp_cfg = 2'b00; b_resp_cfg = 2'b00;
        check("rand.proto", 64'(proto_err), 64'd0);

        // reset while waiting for B
        @(negedge clk);
        set_delays(0, 0, 0, 0, 20);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h400; mem_wdata = 64'h1; mem_strb = 8'hFF;
        @(negedge clk); #1;
        mem_req = 1'b0;
        cnt = 0;
        while (axi_req.b_ready !== 1'b1 && cnt < 20) begin
            @(negedge clk); #1; cnt++;
        end
        check("rst_mid.in_b", 64'(axi_req.b_ready), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid.outputs", 64'({axi_req.ar_valid, axi_req.r_ready, axi_req.aw_valid,
              axi_req.w_valid, axi_req.b_ready, mem_rvalid}), 64'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (mem_rvalid !== 1'b0) bad++;
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
        if (mem_rvalid !== 1'b0) bad++;
        check("rst_mid.no_rvalid", 64'(bad), 64'd0);
        check("rst_mid.rdata_cleared", mem_rdata, 64'd0);
        last_rdata = 64'h0;
        set_delays(0, 0, 0, 0, 0);
        run_op("post_rst_rd", 1'b0, 32'h100, 64'h0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
